// File: rtl/ram_rd_streamer_if.sv
// Handshake bundle for ram_rd_streamer: burst command, RAM read request/response, output stream.
// The streamer uses the slave modport; the command source / RAM / sink side uses master.
interface ram_rd_streamer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned LEN_W  = 4
);
  logic              cmd_val;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_rdy;

  logic              rd_req_en;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_rdy;

  logic              rd_resp_val;
  logic [DATA_W-1:0] rd_resp_data;
  logic              rd_resp_rdy;

  logic              out_val;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_rdy;

  logic              busy;

  modport master (
    output cmd_val, cmd_addr, cmd_len,
    input  cmd_rdy,
    input  rd_req_en, rd_req_addr,
    output rd_req_rdy,
    output rd_resp_val, rd_resp_data,
    input  rd_resp_rdy,
    input  out_val, out_data, out_last,
    output out_rdy,
    input  busy
  );

  modport slave (
    input  cmd_val, cmd_addr, cmd_len,
    output cmd_rdy,
    output rd_req_en, rd_req_addr,
    input  rd_req_rdy,
    input  rd_resp_val, rd_resp_data,
    output rd_resp_rdy,
    output out_val, out_data, out_last,
    input  out_rdy,
    output busy
  );
endinterface

// File: rtl/ram_rd_streamer.sv
// Burst read initiator for a 1R1W RAM: issues sequential reads under a credit limit and
// streams the returned words out of a small FIFO with a last-beat marker.
module ram_rd_streamer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_rd_streamer_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned BPTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W  = BPTR_W + 1;

  localparam logic [CNT_W-1:0]  BUF_FULL  = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_issue_cnt;
  logic [LEN_W-1:0]    r_out_cnt;
  logic [CNT_W-1:0]    r_inflight;
  logic [CNT_W-1:0]    r_fifo_cnt;
  logic [BPTR_W-1:0]   r_wr_ptr;
  logic [BPTR_W-1:0]   r_rd_ptr;
  logic [DATA_W-1:0]   r_mem [BUF_DEPTH];

  logic                r_cmd_rdy;
  logic                r_req_en;
  logic                r_resp_rdy;
  logic                r_out_val;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [LEN_W-1:0]    w_issue_nxt;
  logic [LEN_W-1:0]    w_out_cnt_nxt;
  logic [CNT_W-1:0]    w_inflight_nxt;
  logic [CNT_W-1:0]    w_fifo_cnt_nxt;
  logic [BPTR_W-1:0]   w_wr_ptr_nxt;
  logic [BPTR_W-1:0]   w_rd_ptr_nxt;
  logic [CNT_W:0]      w_credit_used;
  logic                w_req_en_nxt;
  logic                w_last_nxt;
  logic [DATA_W-1:0]   w_head_nxt;

  logic w_cmd_fire;
  logic w_req_fire;
  logic w_push;
  logic w_pop;

  assign w_cmd_fire = bus.cmd_val & r_cmd_rdy;
  assign w_req_fire = r_req_en & bus.rd_req_rdy;
  assign w_push     = bus.rd_resp_val & r_resp_rdy;
  assign w_pop      = r_out_val & bus.out_rdy;

  // Next-state and next-value logic for the FSM, counters and output registers.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_issue_nxt    = r_issue_cnt;
    w_out_cnt_nxt  = r_out_cnt;
    w_inflight_nxt = r_inflight;
    w_fifo_cnt_nxt = r_fifo_cnt;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;

    case (r_state)
      IDLE: begin
        if (w_cmd_fire && (bus.cmd_len != '0)) begin
          w_addr_nxt    = bus.cmd_addr;
          w_issue_nxt   = bus.cmd_len;
          w_out_cnt_nxt = bus.cmd_len;
          w_state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        if (w_req_fire) begin
          w_addr_nxt  = (r_addr == ADDR_LAST) ? '0 : (r_addr + ADDR_W'(1));
          w_issue_nxt = r_issue_cnt - LEN_W'(1);
          if (r_issue_cnt == LEN_W'(1)) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_pop && r_out_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    case ({w_req_fire, w_push})
      2'b10:   w_inflight_nxt = r_inflight + CNT_W'(1);
      2'b01:   w_inflight_nxt = r_inflight - CNT_W'(1);
      default: w_inflight_nxt = r_inflight;
    endcase

    case ({w_push, w_pop})
      2'b10:   w_fifo_cnt_nxt = r_fifo_cnt + CNT_W'(1);
      2'b01:   w_fifo_cnt_nxt = r_fifo_cnt - CNT_W'(1);
      default: w_fifo_cnt_nxt = r_fifo_cnt;
    endcase

    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + BPTR_W'(1);
    end
    if (w_pop) begin
      w_rd_ptr_nxt  = r_rd_ptr + BPTR_W'(1);
      w_out_cnt_nxt = r_out_cnt - LEN_W'(1);
    end

    // Credits cover both words still in the RAM pipe and words parked in the FIFO.
    w_credit_used = {1'b0, w_inflight_nxt} + {1'b0, w_fifo_cnt_nxt};
    w_req_en_nxt  = (w_state_nxt == ISSUE) && (w_credit_used < {1'b0, BUF_FULL});
    w_last_nxt    = (w_fifo_cnt_nxt != '0) && (w_out_cnt_nxt == LEN_W'(1));

    // A word written into an otherwise-empty FIFO becomes the head in the same edge.
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = bus.rd_resp_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
      r_inflight  <= '0;
      r_fifo_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cmd_rdy   <= 1'b0;
      r_req_en    <= 1'b0;
      r_resp_rdy  <= 1'b1;
      r_out_val   <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_addr      <= w_addr_nxt;
      r_issue_cnt <= w_issue_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_inflight  <= w_inflight_nxt;
      r_fifo_cnt  <= w_fifo_cnt_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_cmd_rdy   <= (w_state_nxt == IDLE);
      r_req_en    <= w_req_en_nxt;
      r_resp_rdy  <= (w_fifo_cnt_nxt != BUF_FULL);
      r_out_val   <= (w_fifo_cnt_nxt != '0);
      r_out_data  <= w_head_nxt;
      r_out_last  <= w_last_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.rd_resp_data;
    end
  end

  assign bus.cmd_rdy     = r_cmd_rdy;
  assign bus.rd_req_en   = r_req_en;
  assign bus.rd_req_addr = r_addr;
  assign bus.rd_resp_rdy = r_resp_rdy;
  assign bus.out_val     = r_out_val;
  assign bus.out_data    = r_out_data;
  assign bus.out_last    = r_out_last;
  assign bus.busy        = r_busy;

  // The RAM must never return a word when no FIFO slot is free.
  resp_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.rd_resp_val && (r_fifo_cnt == BUF_FULL)));

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Randomized self-checking bench for ram_rd_streamer with a RAM model and a burst-level
// expected-beat scoreboard.
module tb_ram_rd_streamer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned BUFD   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_rd_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  ram_rd_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BUF_DEPTH(BUFD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  int unsigned exp_addr[$];
  int unsigned exp_data[$];
  bit          exp_last[$];
  int unsigned pend_addr[$];
  int          pend_due[$];
  int          out_cyc[$];

  int cyc = 0;
  int cmd_cyc = 0;
  int outstanding = 0;
  int n_issued = 0;
  bit prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  bit rand_req_rdy = 1'b0;
  bit rand_delay   = 1'b0;
  int out_mode     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic clear_model();
    exp_addr.delete(); exp_data.delete(); exp_last.delete();
    pend_addr.delete(); pend_due.delete();
    outstanding = 0;
    prev_stall  = 1'b0;
  endtask

  // One clock cycle: drive RAM/sink inputs, score all handshakes, advance to next negedge.
  task automatic cycle();
    int unsigned a;
    bus.rd_req_rdy = rand_req_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    case (out_mode)
      0:       bus.out_rdy = 1'b1;
      1:       bus.out_rdy = 1'b0;
      default: bus.out_rdy = 1'($urandom_range(0, 1));
    endcase
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      bus.rd_resp_val  = 1'b1;
      bus.rd_resp_data = mem[pend_addr[0]];
    end else begin
      bus.rd_resp_val  = 1'b0;
      bus.rd_resp_data = $urandom;
    end
    #1;

    if (bus.cmd_val && bus.cmd_rdy) begin
      cmd_cyc = cyc;
      for (int k = 0; k < int'(bus.cmd_len); k++) begin
        a = (int'(bus.cmd_addr) + k) % DEPTH;
        exp_addr.push_back(a);
        exp_data.push_back(32'h100 + a);
        exp_last.push_back(k == int'(bus.cmd_len) - 1);
      end
    end

    if (prev_stall) begin
      check("req_hold_en", 32'(bus.rd_req_en), 32'd1);
      check("req_hold_addr", 32'(bus.rd_req_addr), 32'(prev_addr));
    end
    prev_stall = bus.rd_req_en && !bus.rd_req_rdy;
    prev_addr  = bus.rd_req_addr;

    if (bus.rd_resp_val && bus.rd_resp_rdy) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end

    if (bus.rd_req_en && bus.rd_req_rdy) begin
      n_issued++;
      outstanding++;
      if (exp_addr.size() == 0) check("req_spurious", 32'd1, 32'd0);
      else check("req_addr", 32'(bus.rd_req_addr), exp_addr.pop_front());
      pend_addr.push_back(int'(bus.rd_req_addr));
      pend_due.push_back(cyc + (rand_delay ? int'($urandom_range(1, 3)) : 1));
    end

    if (bus.out_val && bus.out_rdy) begin
      outstanding--;
      out_cyc.push_back(cyc - cmd_cyc);
      if (exp_data.size() == 0) check("out_spurious", 32'd1, 32'd0);
      else begin
        check("out_data", bus.out_data, exp_data.pop_front());
        check("out_last", 32'(bus.out_last), 32'(exp_last.pop_front()));
      end
    end

    if (outstanding > 0) check("credit_limit", 32'(outstanding <= int'(BUFD)), 32'd1);

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_cmd(input int unsigned addr, input int unsigned len);
    bus.cmd_val  = 1'b1;
    bus.cmd_addr = ADDR_W'(addr);
    bus.cmd_len  = LEN_W'(len);
    check("cmd_rdy_idle", 32'(bus.cmd_rdy), 32'd1);
    cycle();
    bus.cmd_val = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_data.size() == 0 && !bus.busy && !bus.out_val) begin
        done = 1'b1;
        break;
      end
      cycle();
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'(32'h100 + i);
    bus.cmd_val = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.rd_req_rdy = 1'b1; bus.rd_resp_val = 1'b0; bus.rd_resp_data = '0;
    bus.out_rdy = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("rst_req_en", 32'(bus.rd_req_en), 32'd0);
    check("rst_resp_rdy", 32'(bus.rd_resp_rdy), 32'd1);
    check("rst_out_val", 32'(bus.out_val), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_req_addr", 32'(bus.rd_req_addr), 32'd0);
    rst_n = 1'b1;
    cycle();
    check("cmd_rdy_after_rst", 32'(bus.cmd_rdy), 32'd1);

    // Basic burst: latency and busy timing
    out_cyc.delete();
    send_cmd(2, 4);
    for (int k = 1; k <= 7; k++) begin
      check("busy_timing", 32'(bus.busy), 32'(k <= 6));
      cycle();
    end
    check("burst_beats", 32'(out_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < out_cyc.size(); i++) check("out_latency", 32'(out_cyc[i]), 32'(3 + i));
    check("exp_empty", 32'(exp_data.size()), 32'd0);

    // Address wrap
    send_cmd(6, 4);
    wait_idle(50);

    // Output backpressure caps issue at the credit limit
    n_issued = 0;
    out_mode = 1;
    send_cmd(0, 8);
    repeat (10) cycle();
    check("stall_issued", 32'(n_issued), 32'(BUFD));
    check("stall_req_en", 32'(bus.rd_req_en), 32'd0);
    out_mode = 0;
    wait_idle(50);

    // Zero-length command then single beat
    send_cmd(3, 0);
    check("len0_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    check("len0_req_en", 32'(bus.rd_req_en), 32'd0);
    check("len0_out_val", 32'(bus.out_val), 32'd0);
    send_cmd(5, 1);
    wait_idle(50);

    // Random RAM stalls, response delays and output backpressure
    rand_req_rdy = 1'b1;
    rand_delay   = 1'b1;
    out_mode     = 2;
    for (int b = 0; b < 30; b++) begin
      repeat ($urandom_range(0, 2)) cycle();
      send_cmd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH));
      wait_idle(400);
    end
    rand_req_rdy = 1'b0;
    rand_delay   = 1'b0;
    out_mode     = 0;

    // Reset in the middle of a burst
    send_cmd(0, 8);
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    check("midrst_out_val", 32'(bus.out_val), 32'd0);
    check("midrst_req_en", 32'(bus.rd_req_en), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    clear_model();
    bus.rd_resp_val = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    send_cmd(0, 2);
    wait_idle(50);
    check("final_outstanding", 32'(outstanding), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
